// File: rtl/rrv64_core_vec_param_pkg.sv
// Shared VRF read-path parameters, request/bank-read payloads and the vaddr-to-bank split.
package rrv64_core_vec_param_pkg;

  localparam int unsigned RPORT_NUM  = 5;
  localparam int unsigned BANK_NUM   = 4;
  localparam int unsigned BPORT_NUM  = 2;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned RS_W       = 16;
  localparam int unsigned FIELD_W    = 2;
  localparam int unsigned BANK_W     = $clog2(BANK_NUM);
  localparam int unsigned BPORT_W    = $clog2(BPORT_NUM);
  localparam int unsigned PTR_W      = $clog2(RPORT_NUM);

  // vaddr = {bank_y, row, bank_x}
  localparam int unsigned BANK_X_BIT = 0;
  localparam int unsigned BANK_Y_BIT = 5;
  localparam int unsigned ROW_LSB    = 1;

  typedef struct packed {
    logic               vld;
    logic [ADDR_W-1:0]  vaddr;
    logic [RS_W-1:0]    rs_idx;
    logic [FIELD_W-1:0] field;
  } vrf_rd_req_t;

  typedef struct packed {
    logic             ren;
    logic [ROW_W-1:0] raddr;
  } vrf_bank_rd_t;

  function automatic logic [BANK_W-1:0] vrf_vaddr2bank(input logic [ADDR_W-1:0] vaddr);
    return {vaddr[BANK_Y_BIT], vaddr[BANK_X_BIT]};
  endfunction

endpackage

// File: rtl/vrf_bank_rr_sel.sv
// Per-bank round-robin picker: grants the first BPORT_NUM requesters scanning from ptr.
module vrf_bank_rr_sel
  import rrv64_core_vec_param_pkg::*;
(
  input  logic [RPORT_NUM-1:0]                req,
  input  logic [PTR_W-1:0]                    ptr,
  output logic [BPORT_NUM-1:0][RPORT_NUM-1:0] gnt_c,
  output logic                                deny_c,
  output logic [PTR_W-1:0]                    nxt_ptr_c
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] cnt;
  logic [PTR_W-1:0] last;

  always_comb begin
    gnt_c = '0;
    sum   = '0;
    idx   = '0;
    cnt   = '0;
    last  = ptr;
    for (int unsigned i = 0; i < RPORT_NUM; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      idx = (sum >= (PTR_W+1)'(RPORT_NUM)) ? PTR_W'(sum - (PTR_W+1)'(RPORT_NUM)) : PTR_W'(sum);
      if (req[idx]) begin
        for (int unsigned k = 0; k < BPORT_NUM; k++) begin
          if (cnt == PTR_W'(k)) begin
            gnt_c[k][idx] = 1'b1;
            last          = idx;
          end
        end
        cnt = cnt + PTR_W'(1);
      end
    end
    deny_c    = cnt > PTR_W'(BPORT_NUM);
    nxt_ptr_c = (last == PTR_W'(RPORT_NUM - 1)) ? '0 : last + PTR_W'(1);
  end

endmodule

// File: rtl/vrf_rd_bank_arb.sv
// VRF read-request bank arbiter and pipe stage feeding the banked register file.
// Build option VRF_RD_MERGE_EN: same-vaddr requests share one bank port.
module vrf_rd_bank_arb
  import rrv64_core_vec_param_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [RPORT_NUM-1:0]                           req_vld_i,
  input  logic [RPORT_NUM-1:0][ADDR_W-1:0]               req_vaddr_i,
  input  logic [RPORT_NUM-1:0][RS_W-1:0]                 req_rs_idx_i,
  input  logic [RPORT_NUM-1:0][FIELD_W-1:0]              req_field_i,
  output logic [RPORT_NUM-1:0]                           req_rdy_o,
  input  logic                                           stall_i,
  input  logic                                           flush_i,
  output logic [BANK_NUM-1:0][BPORT_NUM-1:0]             bank_ren_o,
  output logic [BANK_NUM-1:0][BPORT_NUM-1:0][ROW_W-1:0]  bank_raddr_o,
  output logic [RPORT_NUM-1:0]                           pipe_vld_o,
  output logic [RPORT_NUM-1:0][ADDR_W-1:0]               pipe_vaddr_o,
  output logic [RPORT_NUM-1:0][RS_W-1:0]                 pipe_rs_idx_o,
  output logic [RPORT_NUM-1:0][FIELD_W-1:0]              pipe_field_o,
  output logic [RPORT_NUM-1:0][BANK_W-1:0]               pipe_bank_o,
  output logic [RPORT_NUM-1:0][BPORT_W-1:0]              pipe_bport_o
);

  logic [RPORT_NUM-1:0][BANK_W-1:0]             bank;
  logic [RPORT_NUM-1:0][ROW_W-1:0]              row;
  logic [RPORT_NUM-1:0]                         dup;
  logic [BANK_NUM-1:0][RPORT_NUM-1:0]           req_mask;
  logic [BANK_NUM-1:0][BPORT_NUM-1:0][RPORT_NUM-1:0] rr_gnt;
  logic [BANK_NUM-1:0]                          rr_deny;
  logic [BANK_NUM-1:0][PTR_W-1:0]               rr_nxt;
  logic [BANK_NUM-1:0][PTR_W-1:0]               rr_q;
`ifdef VRF_RD_MERGE_EN
  logic [RPORT_NUM-1:0][PTR_W-1:0]              lead;
`endif

  logic [RPORT_NUM-1:0]                         gnt_dir;
  logic [RPORT_NUM-1:0][BPORT_W-1:0]            bport_dir;
  logic [RPORT_NUM-1:0]                         granted;
  logic [RPORT_NUM-1:0][BPORT_W-1:0]            gbport;
  vrf_rd_req_t  [RPORT_NUM-1:0]                 nxt_pipe;
  vrf_bank_rd_t [BANK_NUM-1:0][BPORT_NUM-1:0]   nxt_bank;

  vrf_rd_req_t  [RPORT_NUM-1:0]                 pipe_q;
  vrf_bank_rd_t [BANK_NUM-1:0][BPORT_NUM-1:0]   bank_q;
  logic [RPORT_NUM-1:0][BANK_W-1:0]             pbank_q;
  logic [RPORT_NUM-1:0][BPORT_W-1:0]            pbport_q;

  // Decode and build per-bank request masks; merged followers stay out of arbitration
  always_comb begin
    dup = '0;
`ifdef VRF_RD_MERGE_EN
    lead = '0;
`endif
    for (int unsigned p = 0; p < RPORT_NUM; p++) begin
      bank[p] = vrf_vaddr2bank(req_vaddr_i[p]);
      row[p]  = req_vaddr_i[p][ROW_LSB +: ROW_W];
`ifdef VRF_RD_MERGE_EN
      lead[p] = PTR_W'(p);
      for (int unsigned q = 0; q < RPORT_NUM; q++) begin
        if (q < p && !dup[p] && req_vld_i[q] && req_vld_i[p] &&
            req_vaddr_i[q] == req_vaddr_i[p]) begin
          dup[p]  = 1'b1;
          lead[p] = PTR_W'(q);
        end
      end
`endif
    end
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      for (int unsigned p = 0; p < RPORT_NUM; p++) begin
        req_mask[b][p] = req_vld_i[p] && (bank[p] == BANK_W'(b)) && !dup[p];
      end
    end
  end

  for (genvar gb = 0; gb < BANK_NUM; gb++) begin : g_bank
    vrf_bank_rr_sel u_rr_sel (
      .req       (req_mask[gb]),
      .ptr       (rr_q[gb]),
      .gnt_c     (rr_gnt[gb]),
      .deny_c    (rr_deny[gb]),
      .nxt_ptr_c (rr_nxt[gb])
    );
  end

  // Collect grants per port and per bank port
  always_comb begin
    gnt_dir   = '0;
    bport_dir = '0;
    nxt_bank  = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      for (int unsigned k = 0; k < BPORT_NUM; k++) begin
        nxt_bank[b][k].ren = |rr_gnt[b][k];
        for (int unsigned p = 0; p < RPORT_NUM; p++) begin
          if (rr_gnt[b][k][p]) begin
            gnt_dir[p]           = 1'b1;
            bport_dir[p]         = BPORT_W'(k);
            nxt_bank[b][k].raddr = row[p];
          end
        end
      end
    end
    granted = gnt_dir;
    gbport  = bport_dir;
`ifdef VRF_RD_MERGE_EN
    for (int unsigned p = 0; p < RPORT_NUM; p++) begin
      if (dup[p]) begin
        granted[p] = gnt_dir[lead[p]];
        gbport[p]  = bport_dir[lead[p]];
      end
    end
`endif
    for (int unsigned p = 0; p < RPORT_NUM; p++) begin
      nxt_pipe[p] = '{vld: granted[p], vaddr: req_vaddr_i[p],
                      rs_idx: req_rs_idx_i[p], field: req_field_i[p]};
    end
    req_rdy_o = granted & {RPORT_NUM{!stall_i && !rst}};
  end

  // Pipe stage and round-robin pointers; flush kills valids but lets pointers advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q   <= '0;
      bank_q   <= '0;
      pbank_q  <= '0;
      pbport_q <= '0;
      rr_q     <= '0;
    end else begin
      if (!stall_i) begin
        pipe_q   <= nxt_pipe;
        bank_q   <= nxt_bank;
        pbank_q  <= bank;
        pbport_q <= gbport;
        for (int unsigned b = 0; b < BANK_NUM; b++) begin
          if (rr_deny[b]) rr_q[b] <= rr_nxt[b];
        end
      end
      if (flush_i) begin
        for (int unsigned p = 0; p < RPORT_NUM; p++) pipe_q[p].vld <= 1'b0;
        for (int unsigned b = 0; b < BANK_NUM; b++) begin
          for (int unsigned k = 0; k < BPORT_NUM; k++) bank_q[b][k].ren <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < RPORT_NUM; p++) begin
      pipe_vld_o[p]    = pipe_q[p].vld;
      pipe_vaddr_o[p]  = pipe_q[p].vaddr;
      pipe_rs_idx_o[p] = pipe_q[p].rs_idx;
      pipe_field_o[p]  = pipe_q[p].field;
    end
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      for (int unsigned k = 0; k < BPORT_NUM; k++) begin
        bank_ren_o[b][k]   = bank_q[b][k].ren;
        bank_raddr_o[b][k] = bank_q[b][k].raddr;
      end
    end
  end

  assign pipe_bank_o  = pbank_q;
  assign pipe_bport_o = pbport_q;

endmodule
